ysyx_22041412_mem_arbiter: RTL and testbench

YSYX_22041412_MEM_ARBITER -- requirements
Module: ysyx_22041412_mem_arbiter

---
 rtl/ysyx_22041412_mem_arbiter_if.sv | 48 ++++
 rtl/ysyx_22041412_mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_ysyx_22041412_mem_arbiter.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22041412_mem_arbiter_if.sv
// Bundle of IF/LSU request-response channels and the shared memory port.
// The arbiter sits on the slave modport; requesters and memory use master.
interface ysyx_22041412_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);
    logic                  if_req_valid;
    logic                  if_req_ready;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_resp_valid;
    logic                  if_resp_ready;
    logic [DATA_WIDTH-1:0] if_rdata;

    logic                  ls_req_valid;
    logic                  ls_req_ready;
    logic [ADDR_WIDTH-1:0] ls_addr;
    logic                  ls_wen;
    logic [2:0]            ls_func3;
    logic [DATA_WIDTH-1:0] ls_wdata;
    logic                  ls_resp_valid;
    logic                  ls_resp_ready;
    logic [DATA_WIDTH-1:0] ls_rdata;

    logic                  mem_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_wen;
    logic [2:0]            mem_func3;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  if_req_valid, if_addr, if_resp_ready,
        input  ls_req_valid, ls_addr, ls_wen, ls_func3, ls_wdata, ls_resp_ready,
        input  mem_rdata,
        output if_req_ready, if_resp_valid, if_rdata,
        output ls_req_ready, ls_resp_valid, ls_rdata,
        output mem_en, mem_addr, mem_wen, mem_func3, mem_wdata
    );

    modport master (
        output if_req_valid, if_addr, if_resp_ready,
        output ls_req_valid, ls_addr, ls_wen, ls_func3, ls_wdata, ls_resp_ready,
        output mem_rdata,
        input  if_req_ready, if_resp_valid, if_rdata,
        input  ls_req_ready, ls_resp_valid, ls_rdata,
        input  mem_en, mem_addr, mem_wen, mem_func3, mem_wdata
    );
endinterface

// File: rtl/ysyx_22041412_mem_arbiter.sv
// Two-requester (IF/LSU) arbiter for a single-cycle-latency memory port.
// LSU has priority; a saturating streak counter lets IF through after STARVE_LIMIT LSU wins.
module ysyx_22041412_mem_arbiter #(
    parameter int ADDR_WIDTH   = 64,
    parameter int DATA_WIDTH   = 64,
    parameter int STARVE_LIMIT = 4
) (
    input logic clk,
    input logic rst,
    ysyx_22041412_mem_arbiter_if.slave bus
);
    localparam int STREAK_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);
    localparam logic [2:0] IF_FUNC3 = 3'b110;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP
    } state_e;

    state_e                state_q,    state_d;
    logic [STREAK_W-1:0]   streak_q,   streak_d;
    logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
    logic                  wen_q,      wen_d;
    logic [2:0]            func3_q,    func3_d;
    logic [DATA_WIDTH-1:0] wdata_q,    wdata_d;
    logic                  owner_q,    owner_d;   // 1 = LSU owns the transaction
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0] ls_rdata_q, ls_rdata_d;

    logic grant_ls;
    logic grant_if;
    logic owner_resp_ready;

    // Grants only in IDLE; ready is the grant itself, so valid&ready == grant.
    always_comb begin
        grant_ls = 1'b0;
        grant_if = 1'b0;
        if (state_q == IDLE && !rst) begin
            if (bus.ls_req_valid && !(bus.if_req_valid && streak_q == STREAK_MAX)) begin
                grant_ls = 1'b1;
            end else if (bus.if_req_valid) begin
                grant_if = 1'b1;
            end
        end
    end

    assign owner_resp_ready = owner_q ? bus.ls_resp_ready : bus.if_resp_ready;

    always_comb begin
        state_d    = state_q;
        streak_d   = streak_q;
        addr_d     = addr_q;
        wen_d      = wen_q;
        func3_d    = func3_q;
        wdata_d    = wdata_q;
        owner_d    = owner_q;
        if_rdata_d = if_rdata_q;
        ls_rdata_d = ls_rdata_q;

        unique case (state_q)
            IDLE: begin
                if (grant_ls) begin
                    addr_d  = bus.ls_addr;
                    wen_d   = bus.ls_wen;
                    func3_d = bus.ls_func3;
                    wdata_d = bus.ls_wdata;
                    owner_d = 1'b1;
                    state_d = ACCESS;
                    if (!bus.if_req_valid) begin
                        streak_d = '0;
                    end else if (streak_q != STREAK_MAX) begin
                        streak_d = streak_q + STREAK_W'(1);
                    end
                end else if (grant_if) begin
                    addr_d   = bus.if_addr;
                    wen_d    = 1'b0;
                    func3_d  = IF_FUNC3;
                    wdata_d  = '0;
                    owner_d  = 1'b0;
                    streak_d = '0;
                    state_d  = ACCESS;
                end
            end
            ACCESS: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (owner_q) begin
                    ls_rdata_d = wen_q ? '0 : bus.mem_rdata;
                end else begin
                    if_rdata_d = wen_q ? '0 : bus.mem_rdata;
                end
                state_d = RESP;
            end
            RESP: begin
                if (owner_resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            streak_q   <= '0;
            addr_q     <= '0;
            wen_q      <= 1'b0;
            func3_q    <= '0;
            wdata_q    <= '0;
            owner_q    <= 1'b0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            streak_q   <= streak_d;
            addr_q     <= addr_d;
            wen_q      <= wen_d;
            func3_q    <= func3_d;
            wdata_q    <= wdata_d;
            owner_q    <= owner_d;
            if_rdata_q <= if_rdata_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    // Status outputs are masked while rst is high so a reset cycle never shows activity.
    assign bus.if_req_ready  = grant_if;
    assign bus.ls_req_ready  = grant_ls;
    assign bus.mem_en        = (state_q == ACCESS) && !rst;
    assign bus.mem_addr      = addr_q;
    assign bus.mem_wen       = wen_q;
    assign bus.mem_func3     = func3_q;
    assign bus.mem_wdata     = wdata_q;
    assign bus.if_resp_valid = (state_q == RESP) && !owner_q && !rst;
    assign bus.ls_resp_valid = (state_q == RESP) &&  owner_q && !rst;
    assign bus.if_rdata      = if_rdata_q;
    assign bus.ls_rdata      = ls_rdata_q;
endmodule

// File: tb/tb_ysyx_22041412_mem_arbiter.sv
// Directed bench for the IF/LSU memory arbiter: one task per scenario, inline checks.
module tb_ysyx_22041412_mem_arbiter;
    logic clk;
    logic rst;
    int   passed;
    int   total;

    ysyx_22041412_mem_arbiter_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) bus ();

    ysyx_22041412_mem_arbiter #(
        .ADDR_WIDTH  (64),
        .DATA_WIDTH  (64),
        .STARVE_LIMIT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns 1 time unit after a rising edge; inputs are driven there, checks after a further #1.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.if_req_valid  = 1'b0;
        bus.if_addr       = '0;
        bus.if_resp_ready = 1'b0;
        bus.ls_req_valid  = 1'b0;
        bus.ls_addr       = '0;
        bus.ls_wen        = 1'b0;
        bus.ls_func3      = '0;
        bus.ls_wdata      = '0;
        bus.ls_resp_ready = 1'b0;
        bus.mem_rdata     = '0;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        clear_inputs();
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        bus.if_req_valid = 1'b1;
        bus.ls_req_valid = 1'b1;
        cyc();
        cyc();
        #1;
        total++; if (bus.if_req_ready !== 1'b0) $display("FAIL rst_if_ready: got %0h want 0", bus.if_req_ready); else passed++;
        total++; if (bus.ls_req_ready !== 1'b0) $display("FAIL rst_ls_ready: got %0h want 0", bus.ls_req_ready); else passed++;
        total++; if (bus.mem_en !== 1'b0) $display("FAIL rst_mem_en: got %0h want 0", bus.mem_en); else passed++;
        total++; if (bus.if_resp_valid !== 1'b0 || bus.ls_resp_valid !== 1'b0)
            $display("FAIL rst_resp_valid: got if=%0h ls=%0h want 0/0", bus.if_resp_valid, bus.ls_resp_valid); else passed++;
        clear_inputs();
        rst = 1'b0;
        cyc();
        #1;
        total++; if (bus.mem_addr !== 64'h0 || bus.mem_wen !== 1'b0 || bus.mem_func3 !== 3'b000 || bus.mem_wdata !== 64'h0)
            $display("FAIL rst_payload: got addr=%h wen=%0h f3=%0h wdata=%h want all 0",
                     bus.mem_addr, bus.mem_wen, bus.mem_func3, bus.mem_wdata); else passed++;
        total++; if (bus.if_rdata !== 64'h0 || bus.ls_rdata !== 64'h0)
            $display("FAIL rst_rdata: got if=%h ls=%h want 0/0", bus.if_rdata, bus.ls_rdata); else passed++;
    endtask

    task automatic test_if_fetch();
        bus.if_req_valid = 1'b1;
        bus.if_addr      = 64'h8000_0000;
        bus.mem_rdata    = 64'h13;
        #1;
        total++; if (bus.if_req_ready !== 1'b1 || bus.ls_req_ready !== 1'b0)
            $display("FAIL if_grant: got if=%0h ls=%0h want 1/0", bus.if_req_ready, bus.ls_req_ready); else passed++;
        cyc();
        bus.if_req_valid = 1'b0;
        #1;
        total++; if (bus.mem_en !== 1'b1) $display("FAIL if_mem_en: got %0h want 1", bus.mem_en); else passed++;
        total++; if (bus.mem_addr !== 64'h8000_0000 || bus.mem_func3 !== 3'b110 || bus.mem_wen !== 1'b0 || bus.mem_wdata !== 64'h0)
            $display("FAIL if_mem_payload: got addr=%h f3=%0h wen=%0h wdata=%h want 80000000/6/0/0",
                     bus.mem_addr, bus.mem_func3, bus.mem_wen, bus.mem_wdata); else passed++;
        cyc();
        #1;
        total++; if (bus.mem_en !== 1'b0 || bus.if_resp_valid !== 1'b0)
            $display("FAIL if_wait: got mem_en=%0h resp=%0h want 0/0", bus.mem_en, bus.if_resp_valid); else passed++;
        cyc();
        #1;
        total++; if (bus.if_resp_valid !== 1'b1 || bus.if_rdata !== 64'h13)
            $display("FAIL if_resp: got valid=%0h rdata=%h want 1/13", bus.if_resp_valid, bus.if_rdata); else passed++;
        total++; if (bus.ls_resp_valid !== 1'b0 || bus.mem_en !== 1'b0 || bus.mem_addr !== 64'h8000_0000)
            $display("FAIL if_resp_side: got ls_valid=%0h mem_en=%0h addr=%h want 0/0/80000000",
                     bus.ls_resp_valid, bus.mem_en, bus.mem_addr); else passed++;
        bus.if_resp_ready = 1'b1;
        cyc();
        bus.if_resp_ready = 1'b0;
        bus.mem_rdata     = 64'h99;
        #1;
        total++; if (bus.if_resp_valid !== 1'b0) $display("FAIL if_resp_done: got %0h want 0", bus.if_resp_valid); else passed++;
        cyc();
        #1;
        total++; if (bus.if_rdata !== 64'h13) $display("FAIL if_rdata_hold: got %h want 13", bus.if_rdata); else passed++;
    endtask

    task automatic test_lsu_store();
        bus.ls_req_valid = 1'b1;
        bus.ls_addr      = 64'h8000_1000;
        bus.ls_wen       = 1'b1;
        bus.ls_func3     = 3'b011;
        bus.ls_wdata     = 64'hDEAD_BEEF;
        #1;
        total++; if (bus.ls_req_ready !== 1'b1 || bus.if_req_ready !== 1'b0)
            $display("FAIL st_grant: got ls=%0h if=%0h want 1/0", bus.ls_req_ready, bus.if_req_ready); else passed++;
        cyc();
        bus.ls_req_valid = 1'b0;
        bus.mem_rdata    = 64'h55;
        #1;
        total++; if (bus.mem_en !== 1'b1 || bus.mem_wen !== 1'b1 || bus.mem_func3 !== 3'b011 ||
                     bus.mem_wdata !== 64'hDEAD_BEEF || bus.mem_addr !== 64'h8000_1000)
            $display("FAIL st_mem: got en=%0h wen=%0h f3=%0h wdata=%h addr=%h want 1/1/3/deadbeef/80001000",
                     bus.mem_en, bus.mem_wen, bus.mem_func3, bus.mem_wdata, bus.mem_addr); else passed++;
        cyc();
        #1;
        total++; if (bus.mem_en !== 1'b0) $display("FAIL st_mem_once: got %0h want 0", bus.mem_en); else passed++;
        cyc();
        #1;
        total++; if (bus.ls_resp_valid !== 1'b1 || bus.ls_rdata !== 64'h0 || bus.if_resp_valid !== 1'b0)
            $display("FAIL st_resp: got valid=%0h rdata=%h if_valid=%0h want 1/0/0",
                     bus.ls_resp_valid, bus.ls_rdata, bus.if_resp_valid); else passed++;
        bus.ls_resp_ready = 1'b1;
        cyc();
        bus.ls_resp_ready = 1'b0;
        bus.ls_wen        = 1'b0;
    endtask

    task automatic test_priority();
        reset_dut();
        bus.if_req_valid  = 1'b1;
        bus.if_addr       = 64'h8000_0040;
        bus.ls_req_valid  = 1'b1;
        bus.ls_addr       = 64'h8000_2000;
        bus.ls_func3      = 3'b010;
        bus.ls_resp_ready = 1'b1;
        bus.if_resp_ready = 1'b1;
        #1;
        total++; if (bus.ls_req_ready !== 1'b1 || bus.if_req_ready !== 1'b0)
            $display("FAIL prio_first: got ls=%0h if=%0h want 1/0", bus.ls_req_ready, bus.if_req_ready); else passed++;
        cyc();
        bus.ls_req_valid = 1'b0;
        for (int unsigned k = 1; k <= 3; k++) begin
            #1;
            total++; if (bus.if_req_ready !== 1'b0 || bus.ls_req_ready !== 1'b0)
                $display("FAIL prio_pending_%0d: got if=%0h ls=%0h want 0/0", k, bus.if_req_ready, bus.ls_req_ready); else passed++;
            if (k == 1) begin
                total++; if (bus.mem_addr !== 64'h8000_2000) $display("FAIL prio_ls_addr: got %h want 80002000", bus.mem_addr); else passed++;
            end
            if (k == 3) begin
                total++; if (bus.ls_resp_valid !== 1'b1) $display("FAIL prio_ls_resp: got %0h want 1", bus.ls_resp_valid); else passed++;
            end
            cyc();
        end
        #1;
        total++; if (bus.if_req_ready !== 1'b1 || bus.ls_req_ready !== 1'b0 || bus.ls_resp_valid !== 1'b0)
            $display("FAIL prio_if_next: got if=%0h ls=%0h ls_valid=%0h want 1/0/0",
                     bus.if_req_ready, bus.ls_req_ready, bus.ls_resp_valid); else passed++;
        cyc();
        bus.if_req_valid = 1'b0;
        #1;
        total++; if (bus.mem_addr !== 64'h8000_0040 || bus.mem_func3 !== 3'b110)
            $display("FAIL prio_if_mem: got addr=%h f3=%0h want 80000040/6", bus.mem_addr, bus.mem_func3); else passed++;
        cyc();
        cyc();
        cyc();
    endtask

    task automatic test_starvation();
        logic exp_ls;
        reset_dut();
        bus.if_req_valid  = 1'b1;
        bus.if_addr       = 64'h8000_0100;
        bus.ls_req_valid  = 1'b1;
        bus.ls_addr       = 64'h8000_3000;
        bus.ls_func3      = 3'b011;
        bus.if_resp_ready = 1'b1;
        bus.ls_resp_ready = 1'b1;
        for (int unsigned slot = 0; slot < 6; slot++) begin
            exp_ls = (slot != 4);
            #1;
            total++; if (bus.ls_req_ready !== exp_ls || bus.if_req_ready !== !exp_ls)
                $display("FAIL starve_slot_%0d: got ls=%0h if=%0h want %0h/%0h",
                         slot, bus.ls_req_ready, bus.if_req_ready, exp_ls, !exp_ls); else passed++;
            cyc();
            if (slot == 4) begin
                #1;
                total++; if (dut.streak_q !== 3'd0) $display("FAIL starve_streak_clr: got %0d want 0", dut.streak_q); else passed++;
            end
            for (int unsigned k = 1; k <= 3; k++) begin
                #1;
                total++; if (bus.ls_req_ready !== 1'b0 || bus.if_req_ready !== 1'b0)
                    $display("FAIL starve_busy_%0d_%0d: got ls=%0h if=%0h want 0/0",
                             slot, k, bus.ls_req_ready, bus.if_req_ready); else passed++;
                cyc();
            end
        end
        clear_inputs();
        cyc();
    endtask

    task automatic test_resp_stall();
        reset_dut();
        bus.ls_req_valid = 1'b1;
        bus.ls_addr      = 64'h0000_0100;
        bus.ls_func3     = 3'b011;
        bus.mem_rdata    = 64'hCAFE;
        bus.if_req_valid = 1'b1;
        bus.if_addr      = 64'h8000_0200;
        cyc();
        bus.ls_req_valid = 1'b0;
        cyc();
        cyc();
        for (int unsigned k = 0; k < 5; k++) begin
            #1;
            total++; if (bus.ls_resp_valid !== 1'b1 || bus.ls_rdata !== 64'hCAFE)
                $display("FAIL stall_hold_%0d: got valid=%0h rdata=%h want 1/cafe", k, bus.ls_resp_valid, bus.ls_rdata); else passed++;
            total++; if (bus.if_req_ready !== 1'b0 || bus.ls_req_ready !== 1'b0 || bus.mem_en !== 1'b0)
                $display("FAIL stall_nogrant_%0d: got if=%0h ls=%0h mem_en=%0h want 0/0/0",
                         k, bus.if_req_ready, bus.ls_req_ready, bus.mem_en); else passed++;
            bus.mem_rdata = 64'h1111 + 64'(k);
            cyc();
        end
        bus.ls_resp_ready = 1'b1;
        cyc();
        bus.ls_resp_ready = 1'b0;
        #1;
        total++; if (bus.ls_resp_valid !== 1'b0 || bus.if_req_ready !== 1'b1)
            $display("FAIL stall_release: got ls_valid=%0h if_ready=%0h want 0/1", bus.ls_resp_valid, bus.if_req_ready); else passed++;
        total++; if (bus.ls_rdata !== 64'hCAFE) $display("FAIL stall_rdata_keep: got %h want cafe", bus.ls_rdata); else passed++;
    endtask

    task automatic test_reset_in_wait();
        reset_dut();
        bus.if_req_valid = 1'b1;
        bus.if_addr      = 64'h40;
        bus.mem_rdata    = 64'h77;
        cyc();
        bus.if_req_valid = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        total++; if (bus.mem_en !== 1'b0 || bus.if_req_ready !== 1'b0 || bus.ls_req_ready !== 1'b0)
            $display("FAIL rstw_idle: got mem_en=%0h if=%0h ls=%0h want 0/0/0",
                     bus.mem_en, bus.if_req_ready, bus.ls_req_ready); else passed++;
        total++; if (bus.if_rdata !== 64'h0) $display("FAIL rstw_rdata: got %h want 0", bus.if_rdata); else passed++;
        for (int unsigned k = 0; k < 6; k++) begin
            total++; if (bus.if_resp_valid !== 1'b0 || bus.ls_resp_valid !== 1'b0 || bus.mem_en !== 1'b0)
                $display("FAIL rstw_quiet_%0d: got if_valid=%0h ls_valid=%0h mem_en=%0h want 0/0/0",
                         k, bus.if_resp_valid, bus.ls_resp_valid, bus.mem_en); else passed++;
            cyc();
            #1;
        end
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_if_fetch();
        test_lsu_store();
        test_priority();
        test_starvation();
        test_resp_stall();
        test_reset_in_wait();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
